// File: rtl/serv_rf_sequencer_if.sv
// Request/grant and transfer-timing signals between the core control logic,
// the register-file sequencer and the serial register-file RAM.
interface serv_rf_sequencer_if;
  logic       start;
  logic       wonly;
  logic       rgnt;
  logic       rreq;
  logic       wreq;
  logic       busy;
  logic       run;
  logic [4:0] cnt;
  logic       cnt0;
  logic       cnt31;
  logic       done;
  logic       err;

  modport master (
    input  start, wonly, rgnt,
    output rreq, wreq, busy, run, cnt, cnt0, cnt31, done, err
  );

  modport slave (
    output start, wonly, rgnt,
    input  rreq, wreq, busy, run, cnt, cnt0, cnt31, done, err
  );
endinterface

// File: rtl/serv_rf_sequencer.sv
// Register-file request sequencer: issues read/write request pulses, waits for
// grant or the fixed write latency, then times the 32-cycle bit-serial window.
module serv_rf_sequencer #(
  parameter int unsigned WLAT        = 2,
  parameter int unsigned GNT_TIMEOUT = 0
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  serv_rf_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRreq,
    StWait,
    StWreq,
    StWdly,
    StRun
  } state_e;

  // Last wait-counter value before abort; unused when the timeout is disabled.
  localparam logic [7:0] TimeoutLast = 8'(GNT_TIMEOUT - 1);
  // Last delay-counter value in WDLY; only meaningful when WLAT >= 2.
  localparam logic [3:0] DlyLast     = 4'(WLAT - 2);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] dly_q, dly_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wait_q  <= '0;
      dly_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      dly_q   <= dly_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    dly_d   = dly_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = bus.wonly ? StWreq : StRreq;
        end
      end
      StRreq: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        // A grant in the final timeout cycle still wins.
        if (bus.rgnt) begin
          state_d = StRun;
          cnt_d   = '0;
          wait_d  = '0;
        end else if (GNT_TIMEOUT != 0) begin
          if (wait_q == TimeoutLast) begin
            state_d = StIdle;
            err_d   = 1'b1;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      StWreq: begin
        dly_d   = '0;
        cnt_d   = '0;
        state_d = (WLAT <= 1) ? StRun : StWdly;
      end
      StWdly: begin
        if (dly_q == DlyLast) begin
          state_d = StRun;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.rreq  = (state_q == StRreq);
  assign bus.wreq  = (state_q == StWreq);
  assign bus.busy  = (state_q != StIdle);
  assign bus.run   = (state_q == StRun);
  assign bus.cnt   = cnt_q;
  assign bus.cnt0  = (state_q == StRun) && (cnt_q == 5'd0);
  assign bus.cnt31 = (state_q == StRun) && (cnt_q == 5'd31);
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_serv_rf_sequencer.sv
// Scoreboard bench for serv_rf_sequencer: each operation pushes its expected
// per-cycle output vectors, and every cycle pops one and compares.
module tb_serv_rf_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   cyc;
  logic pend_done;
  logic pend_err;
  logic [12:0] exp_q[$];

  serv_rf_sequencer_if bus ();

  serv_rf_sequencer #(
    .WLAT       (2),
    .GNT_TIMEOUT(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s c%0d got={rreq,wreq,busy,run,cnt,cnt0,cnt31,done,err}=%b exp=%b",
               tag, cyc, got, exp);
    end
  endtask

  // Expected output vector for one cycle; done/err come from the previous op.
  task automatic push_exp(input logic r, input logic w, input logic b, input logic run,
                          input logic [4:0] cnt);
    logic [12:0] v;
    v = {r, w, b, run, cnt, run && (cnt == 5'd0), run && (cnt == 5'd31), pend_done, pend_err};
    pend_done = 1'b0;
    pend_err  = 1'b0;
    exp_q.push_back(v);
  endtask

  task automatic step(input logic s, input logic w, input logic g, input string tag);
    logic [12:0] obs;
    logic [12:0] exp;
    bus.start = s;
    bus.wonly = w;
    bus.rgnt  = g;
    @(negedge clk);
    obs = {bus.rreq, bus.wreq, bus.busy, bus.run, bus.cnt, bus.cnt0, bus.cnt31,
           bus.done, bus.err};
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s c%0d scoreboard empty got=%b", tag, cyc, obs);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, obs, exp);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_step(input logic g, input string tag);
    push_exp(0, 0, 0, 0, 5'd0);
    step(0, 0, g, tag);
  endtask

  // Read op: grant g cycles after the rreq cycle; optional reset at cnt==abort.
  task automatic read_op(input int g, input logic spur, input int abort);
    push_exp(0, 0, 0, 0, 5'd0);
    step(1, 0, 0, "rd_start");
    push_exp(1, 0, 1, 0, 5'd0);
    step(spur, 0, 1, "rd_rreq");
    for (int i = 2; i <= g; i++) begin
      push_exp(0, 0, 1, 0, 5'd0);
      step(spur, 0, 0, "rd_wait");
    end
    push_exp(0, 0, 1, 0, 5'd0);
    step(spur, 0, 1, "rd_gnt");
    for (int k = 0; k < 32; k++) begin
      push_exp(0, 0, 1, 1, 5'(k));
      if (k == abort) begin
        rst_n = 1'b0;
        step(0, 0, 0, "rd_abort");
        rst_n = 1'b1;
        push_exp(0, 0, 0, 0, 5'd0);
        step(0, 0, 0, "rd_after_rst");
        return;
      end
      step(spur & k[0], spur & k[1], spur, "rd_run");
    end
    pend_done = 1'b1;
  endtask

  task automatic write_op();
    push_exp(0, 0, 0, 0, 5'd0);
    step(1, 1, 0, "wr_start");
    push_exp(0, 1, 1, 0, 5'd0);
    step(0, 0, 1, "wr_wreq");
    push_exp(0, 0, 1, 0, 5'd0);
    step(0, 0, 1, "wr_wdly");
    for (int k = 0; k < 32; k++) begin
      push_exp(0, 0, 1, 1, 5'(k));
      step(0, 0, 0, "wr_run");
    end
    pend_done = 1'b1;
  endtask

  task automatic timeout_op();
    push_exp(0, 0, 0, 0, 5'd0);
    step(1, 0, 0, "to_start");
    push_exp(1, 0, 1, 0, 5'd0);
    step(0, 0, 0, "to_rreq");
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 0, 1, 0, 5'd0);
      step(1, 0, 0, "to_wait");
    end
    pend_err = 1'b1;
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    n_chk     = 0;
    n_err     = 0;
    cyc       = 0;
    pend_done = 1'b0;
    pend_err  = 1'b0;
    bus.start = 1'b0;
    bus.wonly = 1'b0;
    bus.rgnt  = 1'b0;
    @(posedge clk);
    #1;
    push_exp(0, 0, 0, 0, 5'd0);
    step(1, 0, 1, "reset");
    rst_n = 1'b1;
    idle_step(1, "idle_gnt");

    read_op(2, 1'b0, -1);
    idle_step(0, "rd_done");

    write_op();
    idle_step(0, "wr_done");

    timeout_op();
    idle_step(0, "to_err");
    idle_step(0, "to_idle");

    read_op(4, 1'b0, -1);
    idle_step(0, "late_gnt_done");

    read_op(1, 1'b1, 17);
    read_op(3, 1'b1, -1);
    read_op(2, 1'b0, -1);
    idle_step(1, "b2b_done");
    idle_step(1, "idle_gnt2");

    write_op();
    read_op(1, 1'b0, -1);
    idle_step(0, "final_done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serv_rf_sequencer.md
Name: serv_rf_sequencer

Overview:
Initiator side of the register-file request/grant protocol. It turns a single-cycle operation start from the control logic into a registered read-request or write-request pulse. It then waits for the RAM's grant, or a fixed write latency, and times the 32-cycle bit-serial transfer window with a 5-bit bit counter. It sits between the core control/state logic and the multi-ported serial register-file RAM, and it owns all request issue and transfer timing.

Parameters:
WLAT, 2, cycles from o_wreq pulse to first serial write bit (RAM write-side pipeline depth); legal 1..15
GNT_TIMEOUT, 0, max cycles spent in WAIT before abort; 0 disables the timeout; legal 0..255

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  operation start strobe; sampled only in IDLE
i_wonly  in  1  qualifies i_start: 1 = write-only op (trap CSR writeback), 0 = read(+write) op
o_rreq  out  1  read request to RAM, one-cycle pulse
o_wreq  out  1  write request to RAM, one-cycle pulse
i_rgnt  in  1  grant from RAM; only meaningful in WAIT
o_busy  out  1  high in every state except IDLE
o_run  out  1  serial transfer window, high exactly 32 cycles per op
o_cnt  out  5  bit index within window, 0..31; holds 0 outside RUN
o_cnt0  out  1  o_run & (o_cnt==0)
o_cnt31  out  1  o_run & (o_cnt==31)
o_done  out  1  one-cycle pulse after a successful op
o_err  out  1  one-cycle pulse on grant timeout

Behaviour:
- States: IDLE, RREQ, WAIT, WREQ, WDLY, RUN. All outputs are registered or decoded from state and counter regs; no combinational path from inputs to outputs.
- Reset (i_rst_n=0 at clock edge): state=IDLE, o_cnt=0, wait/delay counters=0. All outputs 0. Applies mid-operation; any in-flight request is abandoned with no o_done or o_err.
- IDLE, i_start=1, i_wonly=0: go to RREQ. o_rreq=1 only during the RREQ cycle; next state WAIT.
- IDLE, i_start=1, i_wonly=1: go to WREQ. o_wreq=1 only during the WREQ cycle; next state WDLY, delay counter=0.
- i_start outside IDLE is ignored; no queuing.
- WAIT: if i_rgnt=1, next state is RUN with o_cnt=0. A grant in the same cycle as o_rreq (RREQ state) is ignored. A grant arriving in any state other than WAIT is ignored.
- WAIT timeout (GNT_TIMEOUT>0): the wait counter increments each WAIT cycle. If the counter equals GNT_TIMEOUT-1 and i_rgnt=0, next state is IDLE with o_err=1 for one cycle. A grant in that final cycle wins over the timeout.
- WDLY: stays WLAT-1 cycles counted from the end of the WREQ cycle, then RUN. First RUN cycle is exactly WLAT cycles after the o_wreq cycle.
- RUN: o_run=1 and o_cnt increments each cycle from 0 to 31. When o_cnt==31, next state is IDLE, o_cnt wraps to 0, and o_done=1 in that IDLE cycle.
- i_start in the o_done cycle is accepted, so back-to-back ops are possible. Min read-op period is 2+grant latency+32 cycles.
- o_err and o_done are never high together. o_rreq and o_wreq are never high together.

Test Plan:
- Reset then i_start=1, i_wonly=0 at cycle 0; RAM grant 2 cycles after o_rreq -> o_rreq high cycle 1 only; i_rgnt cycle 3; o_run cycles 4..35; o_cnt0 cycle 4; o_cnt31 cycle 35; o_done cycle 36; o_busy cycles 1..35.
- Write-only op, WLAT=2: i_start,i_wonly=1 at cycle 0 -> o_wreq cycle 1; o_run cycles 3..34; o_done cycle 35; o_rreq never asserted.
- GNT_TIMEOUT=4, i_rgnt held 0 -> WAIT cycles 2..5; o_err pulse cycle 6; o_busy=0 from cycle 6; o_run never asserted. Repeat with i_rgnt=1 at cycle 5 -> RUN from cycle 6, no o_err.
- i_rst_n=0 at o_cnt=17 -> next cycle all outputs 0; no o_done. New i_start then produces a normal sequence.
- i_start pulses during RUN and a spurious i_rgnt in IDLE -> no state change, no extra o_rreq. i_start in the o_done cycle -> o_rreq on the following cycle.
